// File: rtl/fpga_robots_game_tmarb.sv
// Tile map port arbiter: game play (A) and host peek/poke (B) share the video tile map port.
// Optional A-priority with B starvation guard is enabled by FPGA_ROBOTS_TMARB_PRIO_EN.
module fpga_robots_game_tmarb #(
  parameter int unsigned AW         = 13,
  parameter int unsigned DW         = 8,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  // port A: game play
  input  logic          a_req,
  input  logic [AW-1:0] a_adr,
  input  logic          a_wen,
  input  logic [DW-1:0] a_wrt,
  output logic          a_ack,
  output logic          a_rvld,
  // port B: host peek/poke
  input  logic          b_req,
  input  logic [AW-1:0] b_adr,
  input  logic          b_wen,
  input  logic [DW-1:0] b_wrt,
  output logic          b_ack,
  output logic          b_rvld,
  // shared read data
  output logic [DW-1:0] rdat,
  // tile map memory
  output logic [AW-1:0] tm_adr,
  output logic [DW-1:0] tm_wrt,
  output logic          tm_wen,
  input  logic [DW-1:0] tm_red
);

  logic          a_ack_q, a_ack_d;
  logic          b_ack_q, b_ack_d;
  logic          a_rvld_q, a_rvld_d;
  logic          b_rvld_q, b_rvld_d;
  logic [DW-1:0] rdat_q, rdat_d;
  logic [AW-1:0] tm_adr_q, tm_adr_d;
  logic [DW-1:0] tm_wrt_q, tm_wrt_d;
  logic          tm_wen_q, tm_wen_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_tag_q, rd_tag_d;

  logic a_elig, b_elig;
  logic grant_a, grant_b;

  // A requester being acked this cycle has not advanced yet, so it cannot be granted again.
  assign a_elig = a_req & ~a_ack_q;
  assign b_elig = b_req & ~b_ack_q;

`ifdef FPGA_ROBOTS_TMARB_PRIO_EN
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_q, starve_d;
  logic          b_starved;

  assign b_starved = (starve_q >= CW'(STARVE_MAX));

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_elig && b_elig) begin
      if (b_starved) grant_b = 1'b1;
      else           grant_a = 1'b1;
    end else if (a_elig) begin
      grant_a = 1'b1;
    end else if (b_elig) begin
      grant_b = 1'b1;
    end
  end

  // Counts A grants that B sat through; saturates rather than wrapping.
  always_comb begin
    starve_d = starve_q;
    if (grant_b || !b_req) begin
      starve_d = '0;
    end else if (grant_a && b_elig && !b_starved) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  logic last_b_q, last_b_d;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_elig && b_elig) begin
      if (last_b_q) grant_a = 1'b1;
      else          grant_b = 1'b1;
    end else if (a_elig) begin
      grant_a = 1'b1;
    end else if (b_elig) begin
      grant_b = 1'b1;
    end
  end

  always_comb begin
    last_b_d = last_b_q;
    if (grant_a)      last_b_d = 1'b0;
    else if (grant_b) last_b_d = 1'b1;
  end

  // Pointer resets to B so that A wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) last_b_q <= 1'b1;
    else     last_b_q <= last_b_d;
  end
`endif

  // Memory command and ack generation.
  always_comb begin
    tm_adr_d  = tm_adr_q;
    tm_wrt_d  = tm_wrt_q;
    tm_wen_d  = 1'b0;
    a_ack_d   = grant_a;
    b_ack_d   = grant_b;
    rd_pend_d = 1'b0;
    rd_tag_d  = 1'b0;
    if (grant_a) begin
      tm_adr_d  = a_adr;
      tm_wrt_d  = a_wrt;
      tm_wen_d  = a_wen;
      rd_pend_d = ~a_wen;
      rd_tag_d  = 1'b0;
    end else if (grant_b) begin
      tm_adr_d  = b_adr;
      tm_wrt_d  = b_wrt;
      tm_wen_d  = b_wen;
      rd_pend_d = ~b_wen;
      rd_tag_d  = 1'b1;
    end
  end

  // Read return: memory data is valid the cycle the address is on tm_adr.
  always_comb begin
    rdat_d   = rdat_q;
    a_rvld_d = rd_pend_q & ~rd_tag_q;
    b_rvld_d = rd_pend_q & rd_tag_q;
    if (rd_pend_q) rdat_d = tm_red;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tm_adr_q  <= '0;
      tm_wrt_q  <= '0;
      tm_wen_q  <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rvld_q  <= 1'b0;
      b_rvld_q  <= 1'b0;
      rdat_q    <= '0;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= 1'b0;
    end else begin
      tm_adr_q  <= tm_adr_d;
      tm_wrt_q  <= tm_wrt_d;
      tm_wen_q  <= tm_wen_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rvld_q  <= a_rvld_d;
      b_rvld_q  <= b_rvld_d;
      rdat_q    <= rdat_d;
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
    end
  end

  assign a_ack  = a_ack_q;
  assign b_ack  = b_ack_q;
  assign a_rvld = a_rvld_q;
  assign b_rvld = b_rvld_q;
  assign rdat   = rdat_q;
  assign tm_adr = tm_adr_q;
  assign tm_wrt = tm_wrt_q;
  assign tm_wen = tm_wen_q;

endmodule

// File: tb/tb_fpga_robots_game_tmarb.sv
// Directed bench for the tile map arbiter (default round-robin build).
module tb_fpga_robots_game_tmarb;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_wen, b_req, b_wen;
  logic [AW-1:0] a_adr, b_adr;
  logic [DW-1:0] a_wrt, b_wrt;
  logic          a_ack, a_rvld, b_ack, b_rvld;
  logic [DW-1:0] rdat;
  logic [AW-1:0] tm_adr;
  logic [DW-1:0] tm_wrt;
  logic          tm_wen;
  logic [DW-1:0] tm_red;

  int checks = 0;
  int errors = 0;

  // Tile map model: fixed contents plus one writable entry.
  logic          wr_vld = 1'b0;
  logic [AW-1:0] wr_adr = '0;
  logic [DW-1:0] wr_dat = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tm_wen) begin
      wr_vld <= 1'b1;
      wr_adr <= tm_adr;
      wr_dat <= tm_wrt;
    end
  end

  always_comb begin
    tm_red = tm_adr[7:0];
    case (tm_adr)
      13'h0123: tm_red = 8'h5A;
      13'h0010: tm_red = 8'h11;
      13'h0020: tm_red = 8'h22;
      default:  tm_red = tm_adr[7:0];
    endcase
    if (wr_vld && (wr_adr == tm_adr)) tm_red = wr_dat;
  end

  fpga_robots_game_tmarb #(
    .AW        (AW),
    .DW        (DW),
    .STARVE_MAX(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .a_req (a_req),
    .a_adr (a_adr),
    .a_wen (a_wen),
    .a_wrt (a_wrt),
    .a_ack (a_ack),
    .a_rvld(a_rvld),
    .b_req (b_req),
    .b_adr (b_adr),
    .b_wen (b_wen),
    .b_wrt (b_wrt),
    .b_ack (b_ack),
    .b_rvld(b_rvld),
    .rdat  (rdat),
    .tm_adr(tm_adr),
    .tm_wrt(tm_wrt),
    .tm_wen(tm_wen),
    .tm_red(tm_red)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_req = 1'b0; a_wen = 1'b0; a_adr = '0; a_wrt = '0;
    b_req = 1'b0; b_wen = 1'b0; b_adr = '0; b_wrt = '0;
    tick();
    tick();
    chk("rst_tm_adr", 32'(tm_adr), 32'h0);
    chk("rst_tm_wrt", 32'(tm_wrt), 32'h0);
    chk("rst_tm_wen", 32'(tm_wen), 32'h0);
    chk("rst_acks", {a_ack, b_ack}, 32'h0);
    chk("rst_rvlds", {a_rvld, b_rvld}, 32'h0);
    chk("rst_rdat", 32'(rdat), 32'h0);

    // A read 0x0123 -> 0x5A
    rst = 1'b0;
    a_req = 1'b1; a_adr = 13'h0123; a_wen = 1'b0;
    tick();
    chk("t1_a_ack", 32'(a_ack), 32'h1);
    chk("t1_tm_adr", 32'(tm_adr), 32'h0123);
    chk("t1_tm_wen", 32'(tm_wen), 32'h0);
    a_req = 1'b0;
    tick();
    chk("t1_a_rvld", 32'(a_rvld), 32'h1);
    chk("t1_rdat", 32'(rdat), 32'h5A);
    chk("t1_b_rvld", 32'(b_rvld), 32'h0);
    chk("t1_a_ack_once", 32'(a_ack), 32'h0);
    tick();
    chk("t1_a_rvld_pulse", 32'(a_rvld), 32'h0);

    // B write 0x1FFF <- 0xC3
    b_req = 1'b1; b_adr = 13'h1FFF; b_wen = 1'b1; b_wrt = 8'hC3;
    tick();
    chk("t2_b_ack", 32'(b_ack), 32'h1);
    chk("t2_tm_wen", 32'(tm_wen), 32'h1);
    chk("t2_tm_adr", 32'(tm_adr), 32'h1FFF);
    chk("t2_tm_wrt", 32'(tm_wrt), 32'hC3);
    b_req = 1'b0;
    tick();
    chk("t2_tm_wen_pulse", 32'(tm_wen), 32'h0);
    chk("t2_b_ack_pulse", 32'(b_ack), 32'h0);
    chk("t2_no_b_rvld", 32'(b_rvld), 32'h0);
    tick();
    chk("t2_no_b_rvld_late", 32'(b_rvld), 32'h0);

    // Both ports read continuously: A (0x0010) first, then alternating
    a_req = 1'b1; a_adr = 13'h0010; a_wen = 1'b0;
    b_req = 1'b1; b_adr = 13'h0020; b_wen = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t4_a_ack", 32'(a_ack), 32'(i % 2));
      chk("t4_b_ack", 32'(b_ack), 32'((i + 1) % 2));
      chk("t4_tm_adr", 32'(tm_adr), (i % 2 == 1) ? 32'h0010 : 32'h0020);
      if (i >= 2) begin
        chk("t4_a_rvld", 32'(a_rvld), 32'((i + 1) % 2));
        chk("t4_b_rvld", 32'(b_rvld), 32'(i % 2));
        chk("t4_rdat", 32'(rdat), (i % 2 == 0) ? 32'h11 : 32'h22);
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    tick();
    chk("t4_tail_b_rvld", 32'(b_rvld), 32'h1);
    chk("t4_tail_rdat", 32'(rdat), 32'h22);
    chk("t4_tail_acks", {a_ack, b_ack}, 32'h0);
    tick();
    chk("t4_idle_rvlds", {a_rvld, b_rvld}, 32'h0);

    // Read after write: A reads back 0x1FFF
    a_req = 1'b1; a_adr = 13'h1FFF; a_wen = 1'b0;
    tick();
    chk("t3_a_ack", 32'(a_ack), 32'h1);
    a_req = 1'b0;
    tick();
    chk("t3_a_rvld", 32'(a_rvld), 32'h1);
    chk("t3_rdat", 32'(rdat), 32'hC3);

    // A withdraws after losing contention; only B is served
    a_req = 1'b1; a_adr = 13'h0555; a_wen = 1'b1; a_wrt = 8'hFF;
    b_req = 1'b1; b_adr = 13'h0020; b_wen = 1'b0;
    tick();
    chk("t5_b_ack", 32'(b_ack), 32'h1);
    chk("t5_a_ack", 32'(a_ack), 32'h0);
    chk("t5_tm_adr", 32'(tm_adr), 32'h0020);
    chk("t5_tm_wen", 32'(tm_wen), 32'h0);
    a_req = 1'b0; b_req = 1'b0;
    tick();
    chk("t5_no_a_ack", 32'(a_ack), 32'h0);
    chk("t5_no_wen", 32'(tm_wen), 32'h0);
    chk("t5_adr_hold", 32'(tm_adr), 32'h0020);
    chk("t5_b_rvld", 32'(b_rvld), 32'h1);
    chk("t5_rdat", 32'(rdat), 32'h22);
    tick();
    chk("t5_idle_wen", 32'(tm_wen), 32'h0);
    chk("t5_idle_a_rvld", 32'(a_rvld), 32'h0);

    // Reset in the cycle after an A read ack
    a_req = 1'b1; a_adr = 13'h0010; a_wen = 1'b0;
    tick();
    chk("t6_a_ack", 32'(a_ack), 32'h1);
    a_req = 1'b0;
    rst = 1'b1;
    tick();
    chk("t6_no_a_rvld", 32'(a_rvld), 32'h0);
    chk("t6_rdat", 32'(rdat), 32'h0);
    chk("t6_tm_adr", 32'(tm_adr), 32'h0);
    chk("t6_acks", {a_ack, b_ack}, 32'h0);
    rst = 1'b0;
    a_req = 1'b1; a_adr = 13'h0010; a_wen = 1'b0;
    b_req = 1'b1; b_adr = 13'h0020; b_wen = 1'b0;
    tick();
    chk("t6_post_a_ack", 32'(a_ack), 32'h1);
    chk("t6_post_b_ack", 32'(b_ack), 32'h0);
    chk("t6_post_tm_adr", 32'(tm_adr), 32'h0010);
    a_req = 1'b0; b_req = 1'b0;
    tick();
    chk("t6_post_a_rvld", 32'(a_rvld), 32'h1);
    chk("t6_post_rdat", 32'(rdat), 32'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
